// File: rtl/adder_flit_injector_pkg.sv
`default_nettype none
// ============================================================================
// adder_char_pkg : shared state type, default sizes and thermometer-walk
//                  pattern function for the adder flit injector
// Revision: 1.0
// ============================================================================
package adder_char_pkg;

  localparam int c_def_n         = 21;
  localparam int c_def_payload   = 20;
  localparam int c_def_gap       = 7;
  localparam int c_def_packets   = 10;
  localparam int c_def_step_bits = 12;
  localparam int c_cnt_w         = 16;
  localparam int c_thermo_max_w  = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } inj_state_e;

  // Step idx (0..6) of the walk: bits [hi-1:lo] of the 2n-bit word are ones.
  function automatic logic [c_thermo_max_w-1:0] thermo_step(input logic [2:0] idx,
                                                            input int n, input int s);
    logic [c_thermo_max_w-1:0] w;
    int lo;
    int hi;
    w  = '0;
    lo = 0;
    hi = 0;
    case (idx)
      3'd0:    begin lo = 2*n - s;   hi = 2*n; end
      3'd1:    begin lo = 2*n - 2*s; hi = 2*n; end
      3'd2:    begin lo = 2*n - 3*s; hi = 2*n; end
      3'd3:    begin lo = 0;         hi = 3*s; end
      3'd4:    begin lo = 0;         hi = 2*s; end
      3'd5:    begin lo = 0;         hi = s;   end
      default: begin lo = 0;         hi = 0;   end
    endcase
    for (int b = 0; b < c_thermo_max_w; b++) begin
      w[b] = (b >= lo) && (b < hi);
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_flit_injector_if.sv
`default_nettype none
// ============================================================================
// adder_flit_injector_if : valid/ready flit bus carrying the two adder operands
// Revision: 1.0
// ============================================================================
interface adder_flit_injector_if import adder_char_pkg::*; #(
  parameter int N = c_def_n
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] input1;
  logic [N-1:0] input2;

  modport master (output out_valid, output input1, output input2, input out_ready);
  modport slave  (input out_valid, input input1, input input2, output out_ready);
endinterface
`default_nettype wire

// File: rtl/adder_flit_injector_thermo_pattern_gen.sv
`default_nettype none
// ============================================================================
// thermo_pattern_gen : 7-step thermometer-walk word register with clear/advance
// Revision: 1.0
// ============================================================================
module thermo_pattern_gen import adder_char_pkg::*; #(
  parameter int N         = c_def_n,
  parameter int STEP_BITS = c_def_step_bits
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           advance,
  output logic [2*N-1:0] word
);

  localparam int c_word_w = 2 * N;

  logic [2:0]          idx_q, idx_d;
  logic [c_word_w-1:0] word_q, word_d;

  // clear wins so a packet boundary always lands on P1
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = 3'd0;
      word_d = c_word_w'(thermo_step(3'd0, N, STEP_BITS));
    end else if (advance) begin
      idx_d  = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
      word_d = c_word_w'(thermo_step(idx_d, N, STEP_BITS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 3'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule
`default_nettype wire

// File: rtl/adder_flit_injector.sv
`default_nettype none
// ============================================================================
// adder_flit_injector : packetized thermometer-walk operand source for adder
// Revision: 1.0
// ============================================================================
module adder_flit_injector import adder_char_pkg::*; #(
  parameter int N         = c_def_n,
  parameter int PAYLOAD   = c_def_payload,
  parameter int GAP       = c_def_gap,
  parameter int PACKETS   = c_def_packets,
  parameter int STEP_BITS = c_def_step_bits
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [c_cnt_w-1:0]    pkt_cnt,
  output logic [c_cnt_w-1:0]    flit_cnt,
  adder_flit_injector_if.master flit
);

  localparam logic [c_cnt_w-1:0] c_payload_last = c_cnt_w'(PAYLOAD - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_pkt_total    = c_cnt_w'(PACKETS);

  inj_state_e          state_q, state_d;
  logic [c_cnt_w-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [c_cnt_w-1:0]  flit_cnt_q, flit_cnt_d;
  logic [c_cnt_w-1:0]  gap_cnt_q, gap_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                out_valid_q, out_valid_d;
  logic                pat_clear;
  logic                pat_advance;
  logic                handshake;
  logic [2*N-1:0]      pat_word;

  assign handshake = out_valid_q & flit.out_ready;

  always_comb begin
    state_d     = state_q;
    pkt_cnt_d   = pkt_cnt_q;
    flit_cnt_d  = flit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pat_clear   = 1'b0;
    pat_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pkt_cnt_d  = '0;
          flit_cnt_d = '0;
          if (PACKETS == 0) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_SEND;
            pat_clear = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (flit_cnt_q == c_payload_last) begin
            // last flit keeps the word on the bus; next packet reloads P1
            pkt_cnt_d  = pkt_cnt_q + 1'b1;
            flit_cnt_d = '0;
            if (GAP != 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end else if (pkt_cnt_q + 1'b1 == c_pkt_total) begin
              state_d = ST_FIN;
            end else begin
              pat_clear = 1'b1;
            end
          end else begin
            flit_cnt_d  = flit_cnt_q + 1'b1;
            pat_advance = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == c_gap_last) begin
          if (pkt_cnt_q == c_pkt_total) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_SEND;
            pat_clear = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_cnt_q   <= pkt_cnt_d;
      flit_cnt_q  <= flit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  thermo_pattern_gen #(
    .N         (N),
    .STEP_BITS (STEP_BITS)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pat_clear),
    .advance (pat_advance),
    .word    (pat_word)
  );

  assign flit.out_valid = out_valid_q;
  assign flit.input1    = pat_word[N-1:0];
  assign flit.input2    = pat_word[2*N-1:N];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pkt_cnt        = pkt_cnt_q;
  assign flit_cnt       = flit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_flit_injector.sv
`default_nettype none
// ============================================================================
// tb_adder_flit_injector : directed self-checking bench for adder_flit_injector
// Revision: 1.0
// ============================================================================
module tb_adder_flit_injector;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [15:0] pkt0, pkt1, pkt2, flit0, flit1, flit2;
  logic [41:0] w0, w1;
  logic [41:0] pat [7];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_flit_injector_if #(.N(21)) bus0 ();
  adder_flit_injector_if #(.N(21)) bus1 ();
  adder_flit_injector_if #(.N(21)) bus2 ();

  adder_flit_injector #(.N(21), .PAYLOAD(20), .GAP(7), .PACKETS(10), .STEP_BITS(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .pkt_cnt(pkt0), .flit_cnt(flit0), .flit(bus0.master));
  adder_flit_injector #(.N(21), .PAYLOAD(3), .GAP(0), .PACKETS(2), .STEP_BITS(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .pkt_cnt(pkt1), .flit_cnt(flit1), .flit(bus1.master));
  adder_flit_injector #(.N(21), .PAYLOAD(4), .GAP(2), .PACKETS(0), .STEP_BITS(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .pkt_cnt(pkt2), .flit_cnt(flit2), .flit(bus2.master));

  assign w0 = {bus0.input2, bus0.input1};
  assign w1 = {bus1.input2, bus1.input1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pos, exp_pkt, exp_flit, done_c, seq_bad, word_bad, cnt_bad;
  int k, total, bp_bad, r;
  logic exp_v, stall, done_seen;
  logic [41:0] exp_w, stall_w;

  initial begin
    // Walk for N=21, S=12, worked out by hand
    pat[0] = 42'h3FFC0000000;
    pat[1] = 42'h3FFFFFC0000;
    pat[2] = 42'h3FFFFFFFFC0;
    pat[3] = 42'h00FFFFFFFFF;
    pat[4] = 42'h00000FFFFFF;
    pat[5] = 42'h00000000FFF;
    pat[6] = 42'h00000000000;
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy",  64'(busy0), 64'd0);
    check("rst_done",  64'(done0), 64'd0);
    check("rst_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_in1",   64'(bus0.input1), 64'd0);
    check("rst_in2",   64'(bus0.input2), 64'd0);
    check("rst_pkt",   64'(pkt0), 64'd0);
    check("rst_flit",  64'(flit0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- full run, ready high, extra start at cycle 50 ----
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("t1_busy",  64'(busy0), 64'd1);
    check("t1_valid", 64'(bus0.out_valid), 64'd1);
    check("t1_in2",   64'(bus0.input2), 64'h1FFE00);
    check("t1_in1",   64'(bus0.input1), 64'd0);
    check("t1_pkt",   64'(pkt0), 64'd0);
    check("t1_flit",  64'(flit0), 64'd0);
    done_c = 0; seq_bad = 0; word_bad = 0; cnt_bad = 0;
    for (int c = 1; c <= 400; c++) begin
      if (done0) begin
        done_c = c;
        break;
      end
      pos   = (c - 1) % 27;
      exp_v = (c <= 270) && (pos < 20);
      if (bus0.out_valid !== exp_v) seq_bad++;
      if (c <= 270) begin
        // during the gap the last flit (P6, flit 20) stays on the bus
        exp_w    = exp_v ? pat[pos % 7] : pat[5];
        exp_pkt  = (c - 1) / 27 + ((pos >= 20) ? 1 : 0);
        exp_flit = exp_v ? pos : 0;
        if (w0 !== exp_w) word_bad++;
        if (pkt0 !== 16'(exp_pkt) || flit0 !== 16'(exp_flit)) cnt_bad++;
      end
      start0 = (c == 50);
      @(negedge clk);
    end
    start0 = 1'b0;
    check("t1_valid_seq", 64'(seq_bad), 64'd0);
    check("t1_words",     64'(word_bad), 64'd0);
    check("t1_counters",  64'(cnt_bad), 64'd0);
    // run occupies cycles 1..270 after the start edge, done on the next one
    check("t1_done_cycle", 64'(done_c), 64'd271);
    check("t1_done_valid", 64'(bus0.out_valid), 64'd0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("t1_idle_busy",  64'(busy0), 64'd0);
    check("t1_idle_done",  64'(done0), 64'd0);
    check("t1_idle_valid", 64'(bus0.out_valid), 64'd0);
    check("t1_pkt_hold",   64'(pkt0), 64'd10);
    check("t1_word_hold",  64'(w0), 64'(pat[5]));

    // ---- random backpressure ----
    bus0.out_ready = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0; total = 0; bp_bad = 0; stall = 1'b0; done_seen = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (done0) begin
        done_seen = 1'b1;
        break;
      end
      if (stall && (!bus0.out_valid || w0 !== stall_w)) bp_bad++;
      r = $urandom_range(0, 1);
      bus0.out_ready = (r != 0);
      stall = 1'b0;
      if (bus0.out_valid) begin
        if (r != 0) begin
          if (w0 !== pat[k % 7]) bp_bad++;
          k++;
          total++;
          if (k == 20) k = 0;
        end else begin
          stall   = 1'b1;
          stall_w = w0;
        end
      end
      @(negedge clk);
    end
    bus0.out_ready = 1'b1;
    check("bp_done_seen", 64'(done_seen), 64'd1);
    check("bp_total",     64'(total), 64'd200);
    check("bp_errors",    64'(bp_bad), 64'd0);
    check("bp_pkt",       64'(pkt0), 64'd10);
    @(negedge clk);

    // ---- GAP = 0: back-to-back packets of 3 ----
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("t3_valid", 64'(bus1.out_valid), 64'd1);
      check("t3_word",  64'(w1), 64'(pat[(c - 1) % 3]));
      check("t3_flit",  64'(flit1), 64'((c - 1) % 3));
      check("t3_pkt",   64'(pkt1), 64'((c - 1) / 3));
      @(negedge clk);
    end
    check("t3_done",     64'(done1), 64'd1);
    check("t3_end_vld",  64'(bus1.out_valid), 64'd0);
    check("t3_end_pkt",  64'(pkt1), 64'd2);
    @(negedge clk);

    // ---- PACKETS = 0 ----
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t4_done",  64'(done2), 64'd1);
    check("t4_valid", 64'(bus2.out_valid), 64'd0);
    @(negedge clk);
    check("t4_busy_after", 64'(busy2), 64'd0);
    check("t4_done_after", 64'(done2), 64'd0);

    // ---- asynchronous reset mid-packet, then restart ----
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (29) @(negedge clk);
    check("t5_pre_pkt",  64'(pkt0), 64'd1);
    check("t5_pre_flit", 64'(flit0), 64'd2);
    check("t5_pre_word", 64'(w0), 64'(pat[2]));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus0.out_valid), 64'd0);
    check("t5_rst_in1",   64'(bus0.input1), 64'd0);
    check("t5_rst_in2",   64'(bus0.input2), 64'd0);
    check("t5_rst_busy",  64'(busy0), 64'd0);
    check("t5_rst_pkt",   64'(pkt0), 64'd0);
    check("t5_rst_flit",  64'(flit0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_valid", 64'(bus0.out_valid), 64'd0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("t5_re_valid", 64'(bus0.out_valid), 64'd1);
    check("t5_re_in2",   64'(bus0.input2), 64'h1FFE00);
    check("t5_re_in1",   64'(bus0.input1), 64'd0);
    check("t5_re_pkt",   64'(pkt0), 64'd0);
    check("t5_re_flit",  64'(flit0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
